dest_reg_hazard_tracker: RTL
============================

Name: dest_reg_hazard_tracker

Overview:
- Consumes the destination-register address chosen by the EX-stage rt/rd select. Carries it, with its write-enable, through the EX/MEM and MEM/WB slots.
- Compares the tracked destinations against the ID-stage source registers and produces three things:
  - registered forwarding selects for the next EX stage;
  - a load-use stall;
  - WB-side write address/enable.
- Sits between ID/EX control and the EX operand muxes of the 5-stage pipeline.

Parameters:
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  ADDR_W  ID source register A.
- id_rt  input  ADDR_W  ID source register B.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_write_reg  input  ADDR_W  EX destination, from the rt/rd select.
- ex_reg_write  input  1  EX instruction writes the register file.
- ex_mem_read  input  1  EX instruction is a load.
- flush  input  1  branch/jump taken; kill the ID instruction.
- stall  output  1  combinational load-use stall to PC/IF-ID.
- fwd_a_sel  output  2  registered EX operand A select: 00 regfile, 10 MEM result, 01 WB result, 11 reserved.
- fwd_b_sel  output  2  same encoding, operand B.
- mem_write_reg  output  ADDR_W  tracked MEM-slot destination.
- mem_reg_write  output  1  MEM-slot write-enable.
- wb_write_reg  output  ADDR_W  tracked WB-slot destination.
- wb_reg_write  output  1  WB-slot write-enable.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous, active-low. While rst_n=0, every registered output and internal slot is 0: fwd_*_sel=00, mem_/wb_ write_reg=0, mem_/wb_ reg_write=0, stall_count=0. stall is combinational and is also forced to 0.
- Slot shift, every clk edge:
  - MEM slot <= {ex_write_reg, ex_reg_write & ex_valid}.
  - WB slot <= MEM slot.
  - The shift does not pause on stall; a stall inserts a bubble in EX, not MEM.
- Destination 0: any slot with write_reg==0 is treated as non-writing for all compares. It is still shifted as given.
- Definitions:
  - exhit(r) = ex_valid & ex_reg_write & ex_write_reg!=0 & ex_write_reg==r.
  - memhit(r) = mem_reg_write & mem_write_reg!=0 & mem_write_reg==r.
- stall = id_valid & ~flush & ex_mem_read & (exhit(id_rs) | (id_uses_rt & exhit(id_rt))).
- Forwarding is computed for the instruction entering EX next cycle, registered at the edge:
  - If flush | stall | ~id_valid: fwd_a_sel <= 00 and fwd_b_sel <= 00 (bubble).
  - Else, for operand A with r=id_rs: 10 if exhit(r) & ~ex_mem_read; else 01 if memhit(r); else 00.
  - Operand B uses r=id_rt, and only when id_uses_rt; otherwise 00.
  - The newer producer (EX→MEM) always beats the older (MEM→WB) when both match.
- Latency: fwd selects are valid one cycle after the ID compare; stall has zero latency.
- Simultaneous flush and load-use: flush wins; stall=0 and the counter does not increment.
- stall_count increments by 1 on each edge where stall=1. It saturates at all-ones with no wrap.
- Same register on rs and rt: both selects resolve independently and identically.
- Reset asserted mid-operation clears everything immediately. After rst_n rises, the first edge shifts normally.

Optional Feature:
- Macro: HAZARD_WB_BYPASS_EN.
- Defined: one extra WB-slot compare for instructions entering EX.
  - If neither exhit nor memhit matches but the WB slot (nonzero, wb_reg_write) matches the source, select 11: forward the value being written back this cycle.
  - 11 becomes a legal encoding.
- Undefined: no WB compare. The register file must be write-first, and 11 is never produced.

Test Plan:
1. Reset: hold rst_n=0 while driving hits → all outputs 0, stall=0. Release; the first edge behaves normally.
2. ALU back-to-back: EX add writes $8 (ex_reg_write=1, ex_mem_read=0); ID id_rs=8 → stall=0; next cycle fwd_a_sel=10, mem_write_reg=8, mem_reg_write=1.
3. Load-use: EX lw to $9 (ex_mem_read=1); ID id_rt=9, id_uses_rt=1 → stall=1 the same cycle; next cycle fwd_b_sel=00, stall_count=1. Re-present the ID instruction with the load now in MEM → fwd_b_sel=01.
4. Priority and $0:
   - EX writes $5 and MEM slot holds $5; ID rs=5 → fwd_a_sel=10.
   - EX writes $0; ID rs=0 → fwd_a_sel=00, no stall.
5. Flush beats stall: a load-use condition with flush=1 → stall=0, stall_count unchanged, fwd selects 00 next cycle.
6. Saturation and bypass:
   - CNT_W=2 with 5 consecutive stalls → stall_count stops at 3.
   - With HAZARD_WB_BYPASS_EN, a WB-only match on rs → fwd_a_sel=11; without the macro → 00.

Source files
------------

// File: rtl/dest_reg_hazard_tracker.sv
// Destination-register hazard tracker: EX/MEM/WB destination slots, load-use stall,
// registered forwarding selects. Optional WB-slot bypass compare under HAZARD_WB_BYPASS_EN.
module dest_reg_hazard_tracker #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_write_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [ADDR_W-1:0] mem_write_reg,
  output logic              mem_reg_write,
  output logic [ADDR_W-1:0] wb_write_reg,
  output logic              wb_reg_write,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  logic [ADDR_W-1:0] r_mem_write_reg;
  logic              r_mem_reg_write;
  logic [ADDR_W-1:0] r_wb_write_reg;
  logic              r_wb_reg_write;
  logic [1:0]        r_fwd_a_sel;
  logic [1:0]        r_fwd_b_sel;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_ex_wr;
  logic              w_mem_wr;
  logic              w_ex_hit_rs;
  logic              w_ex_hit_rt;
  logic              w_mem_hit_rs;
  logic              w_mem_hit_rt;
  logic              w_stall;
  logic              w_bubble;
  logic [1:0]        w_fwd_a_nxt;
  logic [1:0]        w_fwd_b_nxt;
  logic [CNT_W-1:0]  w_stall_count_nxt;

  // Writers to $0 never count as producers.
  assign w_ex_wr      = ex_valid & ex_reg_write & (ex_write_reg != '0);
  assign w_mem_wr     = r_mem_reg_write & (r_mem_write_reg != '0);
  assign w_ex_hit_rs  = w_ex_wr & (ex_write_reg == id_rs);
  assign w_ex_hit_rt  = w_ex_wr & (ex_write_reg == id_rt);
  assign w_mem_hit_rs = w_mem_wr & (r_mem_write_reg == id_rs);
  assign w_mem_hit_rt = w_mem_wr & (r_mem_write_reg == id_rt);

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic [1:0] SEL_BYP = 2'b11;
  logic w_wb_wr;
  logic w_wb_hit_rs;
  logic w_wb_hit_rt;
  assign w_wb_wr     = r_wb_reg_write & (r_wb_write_reg != '0);
  assign w_wb_hit_rs = w_wb_wr & (r_wb_write_reg == id_rs);
  assign w_wb_hit_rt = w_wb_wr & (r_wb_write_reg == id_rt);
`endif

  // Load-use stall; flush kills the ID instruction so it wins.
  assign w_stall  = rst_n & id_valid & ~flush & ex_mem_read &
                    (w_ex_hit_rs | (id_uses_rt & w_ex_hit_rt));
  assign w_bubble = flush | w_stall | ~id_valid;

  // Forwarding selects for the instruction entering EX; newest producer wins.
  always_comb begin
    w_fwd_a_nxt = SEL_RF;
    w_fwd_b_nxt = SEL_RF;
    if (!w_bubble) begin
      if (w_ex_hit_rs & ~ex_mem_read)      w_fwd_a_nxt = SEL_MEM;
      else if (w_mem_hit_rs)               w_fwd_a_nxt = SEL_WB;
`ifdef HAZARD_WB_BYPASS_EN
      else if (w_wb_hit_rs)                w_fwd_a_nxt = SEL_BYP;
`endif
      if (id_uses_rt) begin
        if (w_ex_hit_rt & ~ex_mem_read)    w_fwd_b_nxt = SEL_MEM;
        else if (w_mem_hit_rt)             w_fwd_b_nxt = SEL_WB;
`ifdef HAZARD_WB_BYPASS_EN
        else if (w_wb_hit_rt)              w_fwd_b_nxt = SEL_BYP;
`endif
      end
    end
  end

  // Saturating stall counter.
  always_comb begin
    w_stall_count_nxt = r_stall_count;
    if (w_stall && (r_stall_count != '1)) w_stall_count_nxt = r_stall_count + CNT_W'(1);
  end

  // Slots shift every edge regardless of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_write_reg <= '0;
      r_mem_reg_write <= 1'b0;
      r_wb_write_reg  <= '0;
      r_wb_reg_write  <= 1'b0;
      r_fwd_a_sel     <= SEL_RF;
      r_fwd_b_sel     <= SEL_RF;
      r_stall_count   <= '0;
    end else begin
      r_mem_write_reg <= ex_write_reg;
      r_mem_reg_write <= ex_reg_write & ex_valid;
      r_wb_write_reg  <= r_mem_write_reg;
      r_wb_reg_write  <= r_mem_reg_write;
      r_fwd_a_sel     <= w_fwd_a_nxt;
      r_fwd_b_sel     <= w_fwd_b_nxt;
      r_stall_count   <= w_stall_count_nxt;
    end
  end

  assign stall         = w_stall;
  assign fwd_a_sel     = r_fwd_a_sel;
  assign fwd_b_sel     = r_fwd_b_sel;
  assign mem_write_reg = r_mem_write_reg;
  assign mem_reg_write = r_mem_reg_write;
  assign wb_write_reg  = r_wb_write_reg;
  assign wb_reg_write  = r_wb_reg_write;
  assign stall_count   = r_stall_count;

endmodule
